// File: rtl/spike_train_encoder.sv
// Spike-pair transmitter: a latched bit vector becomes a synchronous p/n burst, an optional
// staggered per-channel phase (compiled in with SPIKE_ENC_STAGGER_EN), then a quiet tail.
module spike_train_encoder #(
  parameter int NUM_CH      = 2,
  parameter int SYNC_SPIKES = 3,
  parameter int GAP         = 2,
  parameter int QUIET       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] in_bits,
  output logic [NUM_CH-1:0] p_out,
  output logic [NUM_CH-1:0] n_out,
  output logic              busy,
  output logic              done
);
  localparam int M1 = (SYNC_SPIKES > GAP) ? SYNC_SPIKES : GAP;
  localparam int M2 = (M1 > QUIET) ? M1 : QUIET;
  localparam int M3 = (M2 > NUM_CH) ? M2 : NUM_CH;
  localparam int CW = $clog2(M3 + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE_SYNC,
    S_WAIT_SYNC,
`ifdef SPIKE_ENC_STAGGER_EN
    S_FIRE_STAG,
    S_WAIT_STAG,
`endif
    S_QUIET,
    S_DONE
  } state_t;

  // With no quiet tail the last pulse is followed straight by the done cycle.
  localparam state_t TAIL_ST = (QUIET == 0) ? S_DONE : S_QUIET;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] bits_q, bits_d;
  logic [CW-1:0]     spike_cnt_q, spike_cnt_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [NUM_CH-1:0] p_q, p_d;
  logic [NUM_CH-1:0] n_q, n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SPIKE_ENC_STAGGER_EN
  logic [CW-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0] sel;
`endif

  always_comb begin
    state_d     = state_q;
    bits_d      = bits_q;
    spike_cnt_d = spike_cnt_q;
    wait_cnt_d  = wait_cnt_q;
`ifdef SPIKE_ENC_STAGGER_EN
    ch_d        = ch_q;
    sel         = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          bits_d      = in_bits;
          spike_cnt_d = '0;
          wait_cnt_d  = '0;
`ifdef SPIKE_ENC_STAGGER_EN
          ch_d        = '0;
`endif
          state_d     = S_FIRE_SYNC;
        end
      end
      S_FIRE_SYNC: begin
        spike_cnt_d = spike_cnt_q + 1'b1;
        wait_cnt_d  = '0;
        if (int'(spike_cnt_q) + 1 >= SYNC_SPIKES) begin
`ifdef SPIKE_ENC_STAGGER_EN
          state_d = S_WAIT_STAG;
`else
          state_d = TAIL_ST;
`endif
        end else begin
          state_d = S_WAIT_SYNC;
        end
      end
      S_WAIT_SYNC: begin
        if (int'(wait_cnt_q) == GAP - 1) state_d = S_FIRE_SYNC;
        else wait_cnt_d = wait_cnt_q + 1'b1;
      end
`ifdef SPIKE_ENC_STAGGER_EN
      S_WAIT_STAG: begin
        if (int'(wait_cnt_q) == GAP - 1) state_d = S_FIRE_STAG;
        else wait_cnt_d = wait_cnt_q + 1'b1;
      end
      S_FIRE_STAG: begin
        ch_d       = ch_q + 1'b1;
        wait_cnt_d = '0;
        if (int'(ch_q) == NUM_CH - 1) state_d = TAIL_ST;
        else state_d = S_WAIT_STAG;
      end
`endif
      S_QUIET: begin
        if (int'(wait_cnt_q) == QUIET - 1) state_d = S_DONE;
        else wait_cnt_d = wait_cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs decode the upcoming state so each pulse lands in the cycle it belongs to.
    p_d = '0;
    n_d = '0;
    case (state_d)
      S_FIRE_SYNC: begin
        p_d = bits_d;
        n_d = ~bits_d;
      end
`ifdef SPIKE_ENC_STAGGER_EN
      S_FIRE_STAG: begin
        sel = NUM_CH'(1) << ch_d;
        p_d = bits_d & sel;
        n_d = ~bits_d & sel;
      end
`endif
      default: ;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bits_q      <= '0;
      spike_cnt_q <= '0;
      wait_cnt_q  <= '0;
      p_q         <= '0;
      n_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SPIKE_ENC_STAGGER_EN
      ch_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bits_q      <= bits_d;
      spike_cnt_q <= spike_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      p_q         <= p_d;
      n_q         <= n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SPIKE_ENC_STAGGER_EN
      ch_q        <= ch_d;
`endif
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign p_out    = p_q;
  assign n_out    = n_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_spike_train_encoder.sv
// Directed bench for spike_train_encoder: default-parameter instance plus an edge-parameter
// instance (SYNC_SPIKES=1, GAP=1, QUIET=0); expectations follow SPIKE_ENC_STAGGER_EN.
module tb_spike_train_encoder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, e_valid;
  logic [1:0] in_bits, e_bits;
  logic       in_ready, e_ready;
  logic [1:0] p_out, n_out, e_p, e_n;
  logic       busy, done, e_busy, e_done;

  int vectors = 0;
  int miscompares = 0;

`ifdef SPIKE_ENC_STAGGER_EN
  localparam bit STAG   = 1'b1;
  localparam int M_DONE = 19;
  localparam int E_PER  = 7;
`else
  localparam bit STAG   = 1'b0;
  localparam int M_DONE = 13;
  localparam int E_PER  = 3;
`endif

  always #5 clk = ~clk;

  spike_train_encoder #(.NUM_CH(2), .SYNC_SPIKES(3), .GAP(2), .QUIET(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .p_out(p_out), .n_out(n_out), .busy(busy), .done(done));

  spike_train_encoder #(.NUM_CH(2), .SYNC_SPIKES(1), .GAP(1), .QUIET(0)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(e_valid), .in_ready(e_ready), .in_bits(e_bits),
    .p_out(e_p), .n_out(e_n), .busy(e_busy), .done(e_done));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [1:0] ep, input logic [1:0] en,
                          input logic eb, input logic ed, input logic er);
    chk({tag, ".p_out"}, 32'(p_out), 32'(ep));
    chk({tag, ".n_out"}, 32'(n_out), 32'(en));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
  endtask

  task automatic chk_edge(input string tag, input logic [1:0] ep, input logic [1:0] en,
                          input logic eb, input logic ed, input logic er);
    chk({tag, ".e_p"}, 32'(e_p), 32'(ep));
    chk({tag, ".e_n"}, 32'(e_n), 32'(en));
    chk({tag, ".e_busy"}, 32'(e_busy), 32'(eb));
    chk({tag, ".e_done"}, 32'(e_done), 32'(ed));
    chk({tag, ".e_ready"}, 32'(e_ready), 32'(er));
  endtask

  // Hand-derived schedule for the default instance, c = cycles after the acceptance cycle.
  task automatic exp_main(input int c, input logic [1:0] b, output logic [1:0] ep,
                          output logic [1:0] en, output logic eb, output logic ed,
                          output logic er);
    ep = 2'b00;
    en = 2'b00;
    if (c == 1 || c == 4 || c == 7) begin
      ep = b;
      en = ~b;
    end else if (STAG && c == 10) begin
      ep = b & 2'b01;
      en = ~b & 2'b01;
    end else if (STAG && c == 13) begin
      ep = b & 2'b10;
      en = ~b & 2'b10;
    end
    eb = (c >= 1) && (c < M_DONE);
    ed = (c == M_DONE);
    er = (c == 0) || (c > M_DONE);
  endtask

  // Edge instance with in_valid held high repeats with period E_PER.
  task automatic exp_edge(input int c, input logic [1:0] b, output logic [1:0] ep,
                          output logic [1:0] en, output logic eb, output logic ed,
                          output logic er);
    int o;
    o  = c % E_PER;
    ep = 2'b00;
    en = 2'b00;
    if (o == 1) begin
      ep = b;
      en = ~b;
    end else if (STAG && o == 3) begin
      ep = b & 2'b01;
      en = ~b & 2'b01;
    end else if (STAG && o == 5) begin
      ep = b & 2'b10;
      en = ~b & 2'b10;
    end
    eb = (o != 0) && (o != E_PER - 1);
    ed = (o == E_PER - 1);
    er = (o == 0);
  endtask

  initial begin
    logic [1:0] ep, en;
    logic       eb, ed, er;

    // Reset held with in_valid asserted: nothing may be accepted.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_bits  = 2'b01;
    e_valid  = 1'b1;
    e_bits   = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    chk_main("rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    chk_edge("rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    e_valid  = 1'b0;
    rst_n    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_main("post_rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    // Transaction 2'b01.
    in_bits  = 2'b01;
    in_valid = 1'b1;
    for (int c = 1; c <= M_DONE + 1; c++) begin
      @(posedge clk);
      #1;
      exp_main(c, 2'b01, ep, en, eb, ed, er);
      chk_main($sformatf("t01.c%0d", c), ep, en, eb, ed, er);
      if (c == 1) in_valid = 1'b0;
    end

    // Transaction 2'b11 with input changed to 2'b00 and held valid while busy.
    in_bits  = 2'b11;
    in_valid = 1'b1;
    for (int c = 1; c <= M_DONE + 2; c++) begin
      @(posedge clk);
      #1;
      exp_main(c, 2'b11, ep, en, eb, ed, er);
      chk_main($sformatf("t11.c%0d", c), ep, en, eb, ed, er);
      if (c == 5) begin
        in_bits  = 2'b00;
        in_valid = 1'b1;
      end
      if (c == M_DONE) in_valid = 1'b0;
    end

    // Reset during the cycle-4 pulse.
    in_bits  = 2'b10;
    in_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      exp_main(c, 2'b10, ep, en, eb, ed, er);
      chk_main($sformatf("t10.c%0d", c), ep, en, eb, ed, er);
      if (c == 1) in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk_main("async_rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk);
      #1;
      chk_main($sformatf("after_rst.c%0d", c), 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    end

    // Edge parameters with back-to-back in_valid.
    e_bits  = 2'b01;
    e_valid = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      exp_edge(c, 2'b01, ep, en, eb, ed, er);
      chk_edge($sformatf("edge.c%0d", c), ep, en, eb, ed, er);
    end
    e_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
